// File: rtl/acc_arb_if.sv
// Request lanes from the ACC writers plus the arbitrated ACC write port.
interface acc_arb_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]   i_req;
   logic [N_REQ-1:0]   i_lock;
   logic [2*N_REQ-1:0] i_op;
   logic [8*N_REQ-1:0] i_data;
   logic [N_REQ-1:0]   o_gnt;
   logic [1:0]         o_op;
   logic [7:0]         o_byte;
   logic               o_busy;
   logic               o_lock_err;

   modport slave (
      input  i_req, i_lock, i_op, i_data,
      output o_gnt, o_op, o_byte, o_busy, o_lock_err
   );

   modport master (
      output i_req, i_lock, i_op, i_data,
      input  o_gnt, o_op, o_byte, o_busy, o_lock_err
   );
endinterface

// File: rtl/acc_arb.sv
// Accumulator write-port arbiter: round-robin among ALU, SFR bus and debug,
// with a bounded lock that lets one requester own the port for a burst.
module acc_arb #(
   parameter int         N_REQ    = 3,
   parameter logic [7:0] LOCK_MAX = 8'd64
) (
   input logic      i_clk,
   input logic      i_rst,
   acc_arb_if.slave bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state_r, state_nx;
   logic [PW-1:0]     ptr_r, ptr_nx;
   logic [PW-1:0]     owner_r, owner_nx;
   logic [7:0]        cnt_r, cnt_nx;
   logic [N_REQ-1:0]  gnt_r, gnt_nx;
   logic [1:0]        op_r, op_nx;
   logic [7:0]        byte_r, byte_nx;
   logic              busy_r, busy_nx;
   logic              err_r, err_nx;

   logic [N_REQ-1:0]  elig_s;
   logic              found_s;
   logic [PW-1:0]     win_s;
   logic              grant_s;
   logic [PW-1:0]     gidx_s;
   logic [1:0]        gop_s;

   // Eligibility and round-robin winner starting just after the last winner.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      for (int n = 0; n < N_REQ; n++) begin
         elig_s[n] = bus.i_req[n] & (|bus.i_op[2*n +: 2]);
      end
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found_s && elig_s[(int'(ptr_r) + k) % N_REQ]) begin
            found_s = 1'b1;
            win_s   = PW'((int'(ptr_r) + k) % N_REQ);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic and next values of the registered ACC port.
   always_comb begin
      state_nx = state_r;
      ptr_nx   = ptr_r;
      owner_nx = owner_r;
      cnt_nx   = cnt_r;
      gnt_nx   = '0;
      op_nx    = 2'b00;
      byte_nx  = byte_r;
      err_nx   = 1'b0;
      grant_s  = 1'b0;
      gidx_s   = '0;
      gop_s    = 2'b00;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               grant_s = 1'b1;
               gidx_s  = win_s;
               ptr_nx  = win_s;
               if (bus.i_lock[win_s]) begin
                  state_nx = LOCKED;
                  owner_nx = win_s;
                  cnt_nx   = 8'd0;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         LOCKED: begin
            cnt_nx = cnt_r + 8'd1;
            gidx_s = owner_r;
            if (!bus.i_lock[owner_r]) begin
               // Voluntary release still serves the owner's last transaction.
               state_nx = IDLE;
               cnt_nx   = 8'd0;
               grant_s  = elig_s[owner_r];
            end else if (cnt_nx == LOCK_MAX - 8'd1) begin
               // Forced release withholds the grant and parks the pointer on
               // the owner so everyone else is searched first.
               state_nx = IDLE;
               cnt_nx   = 8'd0;
               err_nx   = 1'b1;
               ptr_nx   = owner_r;
            end else begin
               grant_s  = elig_s[owner_r];
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
      if (grant_s) begin
         gop_s           = bus.i_op[{gidx_s, 1'b0} +: 2];
         gnt_nx[gidx_s]  = 1'b1;
         op_nx           = gop_s[0] ? 2'b01 : 2'b10;
         byte_nx         = bus.i_data[{gidx_s, 3'b000} +: 8];
      end else begin
         byte_nx = byte_r;
      end
      busy_nx = (state_nx == LOCKED);
   end

   // FSM state, arbitration pointer, lock counter and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r <= IDLE;
         ptr_r   <= PW'(N_REQ - 1);
         owner_r <= '0;
         cnt_r   <= 8'd0;
         gnt_r   <= '0;
         op_r    <= 2'b00;
         byte_r  <= 8'h00;
         busy_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         ptr_r   <= ptr_nx;
         owner_r <= owner_nx;
         cnt_r   <= cnt_nx;
         gnt_r   <= gnt_nx;
         op_r    <= op_nx;
         byte_r  <= byte_nx;
         busy_r  <= busy_nx;
         err_r   <= err_nx;
      end
   end

   assign bus.o_gnt      = gnt_r;
   assign bus.o_op       = op_r;
   assign bus.o_byte     = byte_r;
   assign bus.o_busy     = busy_r;
   assign bus.o_lock_err = err_r;
endmodule

// File: tb/tb_acc_arb.sv
// Randomised and directed bench for acc_arb against a queue-based priority model.
module tb_acc_arb;
   localparam int         N  = 3;
   localparam logic [7:0] LM = 8'd64;

   logic i_clk;
   logic i_rst;
   int   n_err;
   int   n_chk;

   acc_arb_if #(.N_REQ(N)) bus ();

   acc_arb #(.N_REQ(N), .LOCK_MAX(LM)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Behavioural model state: lock tracked by start timestamp, not a counter.
   bit         m_locked;
   int         m_owner;
   int         m_ptr;
   int         cyc_no;
   int         lock_start;
   logic [2:0] e_gnt;
   logic [1:0] e_op;
   logic [7:0] e_byte;
   logic       e_busy;
   logic       e_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = N - 1;
      e_gnt    = 3'b000;
      e_op     = 2'b00;
      e_byte   = 8'h00;
      e_busy   = 1'b0;
      e_err    = 1'b0;
   endtask

   task automatic model_step();
      int         order[$];
      int         w;
      bit         found;
      bit         was_idle;
      logic [2:0] el;
      cyc_no++;
      for (int n = 0; n < N; n++) el[n] = bus.i_req[n] && (bus.i_op[2*n +: 2] != 2'b00);
      e_gnt    = 3'b000;
      e_op     = 2'b00;
      e_err    = 1'b0;
      found    = 1'b0;
      w        = 0;
      was_idle = !m_locked;
      if (was_idle) begin
         for (int k = 1; k <= N; k++) order.push_back((m_ptr + k) % N);
      end else if (!bus.i_lock[m_owner]) begin
         m_locked = 1'b0;
         order.push_back(m_owner);
      end else if (cyc_no - lock_start == int'(LM) - 1) begin
         m_locked = 1'b0;
         e_err    = 1'b1;
         m_ptr    = m_owner;
      end else begin
         order.push_back(m_owner);
      end
      foreach (order[i]) begin
         if (!found && el[order[i]]) begin
            found = 1'b1;
            w     = order[i];
         end
      end
      if (found) begin
         e_gnt[w] = 1'b1;
         e_op     = bus.i_op[2*w] ? 2'b01 : 2'b10;
         e_byte   = bus.i_data[8*w +: 8];
         if (was_idle) begin
            m_ptr = w;
            if (bus.i_lock[w]) begin
               m_locked   = 1'b1;
               m_owner    = w;
               lock_start = cyc_no;
            end
         end
      end
      e_busy = m_locked;
   endtask

   // Advance the model on each edge and compare every output just after it.
   always @(posedge i_clk) begin
      if (!i_rst) model_reset();
      else model_step();
      #1;
      chk("gnt", 32'(bus.o_gnt), 32'(e_gnt));
      chk("op", 32'(bus.o_op), 32'(e_op));
      chk("byte", 32'(bus.o_byte), 32'(e_byte));
      chk("busy", 32'(bus.o_busy), 32'(e_busy));
      chk("lock_err", 32'(bus.o_lock_err), 32'(e_err));
      chk("onehot_op", 32'($onehot0(bus.o_gnt) && ((bus.o_op != 2'b00) == (bus.o_gnt != 3'b000))), 32'd1);
   end

   task automatic drive(input logic [2:0] req, input logic [2:0] lk, input logic [5:0] op, input logic [23:0] d);
      @(negedge i_clk);
      bus.i_req  = req;
      bus.i_lock = lk;
      bus.i_op   = op;
      bus.i_data = d;
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #2;
   endtask

   logic [2:0] exp_g[4];
   logic [7:0] exp_b[4];
   int         err_idx;
   int         err_seen;
   logic       busy_at_err;
   logic [2:0] first_after;

   initial begin
      n_err = 0; n_chk = 0; cyc_no = 0; lock_start = 0;
      model_reset();
      i_rst = 1'b0;
      bus.i_req = 3'b000; bus.i_lock = 3'b000; bus.i_op = 6'b000000; bus.i_data = 24'h000000;
      repeat (3) @(posedge i_clk);
      #2;
      chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
      chk("rst_op", 32'(bus.o_op), 32'd0);
      chk("rst_byte", 32'(bus.o_byte), 32'd0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);

      // Plain round robin from reset.
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_b = '{8'hA5, 8'h3C, 8'hF0, 8'hA5};
      @(negedge i_clk);
      i_rst = 1'b1;
      bus.i_req = 3'b111; bus.i_op = 6'b010101; bus.i_data = 24'hF03CA5;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rr_gnt", 32'(bus.o_gnt), 32'(exp_g[i]));
         chk("rr_byte", 32'(bus.o_byte), 32'(exp_b[i]));
      end

      // Bit write from the SFR bus, then byte hold when idle.
      drive(3'b010, 3'b000, 6'b001000, 24'h000B00);
      cyc();
      chk("bit_gnt", 32'(bus.o_gnt), 32'h2);
      chk("bit_op", 32'(bus.o_op), 32'h2);
      chk("bit_byte", 32'(bus.o_byte), 32'h0B);
      drive(3'b000, 3'b000, 6'b000000, 24'h123456);
      cyc();
      chk("hold_gnt", 32'(bus.o_gnt), 32'h0);
      chk("hold_byte", 32'(bus.o_byte), 32'h0B);

      // Op 00 is ineligible even with lock; op 11 issues as a byte write.
      drive(3'b001, 3'b001, 6'b000000, 24'h000077);
      cyc();
      chk("op00_gnt", 32'(bus.o_gnt), 32'h0);
      chk("op00_busy", 32'(bus.o_busy), 32'h0);
      drive(3'b001, 3'b000, 6'b000011, 24'h00005A);
      cyc();
      chk("op11_op", 32'(bus.o_op), 32'h1);
      chk("op11_byte", 32'(bus.o_byte), 32'h5A);

      // Lock by requester 0 while 1 and 2 wait.
      drive(3'b100, 3'b000, 6'b010000, 24'h000000);
      cyc();
      drive(3'b111, 3'b001, 6'b010101, 24'h332211);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("lock_gnt", 32'(bus.o_gnt), 32'h1);
         chk("lock_busy", 32'(bus.o_busy), 32'h1);
      end
      drive(3'b110, 3'b000, 6'b010101, 24'h332211);
      cyc();
      chk("unlock_busy", 32'(bus.o_busy), 32'h0);
      cyc();
      chk("after_lock_g1", 32'(bus.o_gnt), 32'h2);
      cyc();
      chk("after_lock_g2", 32'(bus.o_gnt), 32'h4);

      // Requester 2 over-holds the lock and is forcibly released.
      drive(3'b100, 3'b100, 6'b010101, 24'hCCBBAA);
      cyc();
      chk("flock_busy", 32'(bus.o_busy), 32'h1);
      err_idx = 0; err_seen = 0; busy_at_err = 1'b1; first_after = 3'b000;
      drive(3'b111, 3'b100, 6'b010101, 24'hCCBBAA);
      for (int i = 1; i < 70; i++) begin
         if (i > 1) @(negedge i_clk);
         cyc();
         if (bus.o_lock_err) begin
            err_seen++;
            err_idx     = i;
            busy_at_err = bus.o_busy;
         end else if (err_seen > 0 && first_after == 3'b000) begin
            first_after = bus.o_gnt;
         end
      end
      chk("flock_err_count", 32'(err_seen), 32'd1);
      chk("flock_err_cycle", 32'(err_idx), 32'd63);
      chk("flock_busy_fall", 32'(busy_at_err), 32'd0);
      chk("flock_next_gnt", 32'(first_after), 32'h1);
      drive(3'b000, 3'b000, 6'b000000, 24'h000000);
      cyc();
      cyc();

      // Asynchronous reset while locked with a grant on the port.
      drive(3'b010, 3'b010, 6'b000100, 24'h00C300);
      cyc();
      chk("arst_pre_gnt", 32'(bus.o_gnt), 32'h2);
      @(negedge i_clk);
      #2;
      i_rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(bus.o_gnt), 32'h0);
      chk("arst_op", 32'(bus.o_op), 32'h0);
      chk("arst_byte", 32'(bus.o_byte), 32'h0);
      chk("arst_busy", 32'(bus.o_busy), 32'h0);
      drive(3'b111, 3'b000, 6'b010101, 24'h030201);
      @(negedge i_clk);
      i_rst = 1'b1;
      cyc();
      chk("arst_first_gnt", 32'(bus.o_gnt), 32'h1);

      // Random traffic with occasional resets.
      repeat (800) begin
         @(negedge i_clk);
         i_rst      = ($urandom_range(99) != 0);
         bus.i_req  = 3'($urandom);
         bus.i_lock = 3'($urandom & $urandom);
         bus.i_op   = 6'($urandom);
         bus.i_data = 24'($urandom);
      end
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #3;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
